// File: rtl/i2c_master_engine.sv
// rtl/i2c_master_engine.sv - byte-level I2C master with START/byte/STOP sequencer and legacy bit-bang pads
module i2c_master_engine #(
  parameter int DIV_W     = 10,
  parameter int DIV_RESET = 124
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  Addr,
  output logic [15:0] DataRd,
  input  logic [15:0] DataWr,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  output logic        SdaOut,
  input  logic        SdaIn,
  output logic        Scl,
  output logic        Irq
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

  state_t           state_q;
  logic [1:0]       qtr_q;
  logic [3:0]       bit_q;
  logic [DIV_W-1:0] cnt_q, div_q;
  logic             busy_q, done_q, held_q, rx_nack_q, irq_en_q;
  logic             sda_dir_q, scl_reg_q, sda_out_reg_q;
  logic [7:0]       tx_q, rx_q;
  logic             stop_q, wr_q, rd_q, ack_q;
  logic             pull_q, scl_q;

  state_t     st_d, ent_st_d;
  logic [1:0] qtr_d;
  logic [3:0] bit_d;
  logic       fin_d;
  logic       wr_en, cmd_wr, eng_pads;
  logic       unused_ok;

  // SDA pull-down for a data/ACK bit; a 1 bit on a write releases the line.
  function automatic logic bit_pull(input logic is_wr, input logic [3:0] b,
                                    input logic [7:0] tx, input logic ack);
    logic [7:0] t;
    t = tx << b;
    if (b == 4'd8) bit_pull = is_wr ? 1'b0 : ~ack;
    else           bit_pull = is_wr ? ~t[7] : 1'b0;
  endfunction

  // Returns {sda_pull, scl_level} for a given phase quarter.
  function automatic logic [1:0] pads(input state_t st, input logic [1:0] q, input logic pull);
    case (st)
      S_START: pads = (q == 2'd0) ? 2'b01 : (q == 2'd3) ? 2'b10 : 2'b11;
      S_BIT:   pads = {pull, (q == 2'd1) || (q == 2'd2)};
      S_STOP:  pads = (q == 2'd0) ? 2'b10 : (q == 2'd1) ? 2'b11 : 2'b01;
      default: pads = 2'b01;
    endcase
  endfunction

  assign wr_en     = En & Wr;
  assign cmd_wr    = wr_en && (Addr == 3'd2) && !busy_q;
  assign unused_ok = ^{Rd, DataWr[15:13]};

  always_comb begin
    if (DataWr[8])                  ent_st_d = S_START;
    else if (DataWr[10] | DataWr[11]) ent_st_d = S_BIT;
    else if (DataWr[9])             ent_st_d = S_STOP;
    else                            ent_st_d = S_IDLE;
  end

  always_comb begin
    st_d  = state_q;
    qtr_d = qtr_q + 2'd1;
    bit_d = bit_q;
    fin_d = 1'b0;
    if (qtr_q == 2'd3) begin
      case (state_q)
        S_START: begin
          if (wr_q | rd_q) begin
            st_d  = S_BIT;
            bit_d = 4'd0;
          end else if (stop_q) st_d = S_STOP;
          else                 fin_d = 1'b1;
        end
        S_BIT: begin
          if (bit_q != 4'd8)   bit_d = bit_q + 4'd1;
          else if (stop_q)     st_d = S_STOP;
          else                 fin_d = 1'b1;
        end
        default: fin_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      qtr_q         <= 2'd0;
      bit_q         <= 4'd0;
      cnt_q         <= '0;
      div_q         <= DIV_W'(DIV_RESET);
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      held_q        <= 1'b0;
      rx_nack_q     <= 1'b0;
      irq_en_q      <= 1'b0;
      sda_dir_q     <= 1'b0;
      scl_reg_q     <= 1'b0;
      sda_out_reg_q <= 1'b0;
      tx_q          <= 8'd0;
      rx_q          <= 8'd0;
      stop_q        <= 1'b0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      ack_q         <= 1'b0;
      pull_q        <= 1'b0;
      scl_q         <= 1'b1;
    end else begin
      if (wr_en && Addr == 3'd0) begin
        irq_en_q <= DataWr[7];
        if (!busy_q && !held_q) {sda_dir_q, scl_reg_q, sda_out_reg_q} <= DataWr[2:0];
        if (DataWr[5]) done_q <= 1'b0;
      end
      if (wr_en && Addr == 3'd1 && !busy_q) div_q <= DataWr[DIV_W-1:0];

      if (cmd_wr) begin
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        tx_q    <= DataWr[7:0];
        stop_q  <= DataWr[9];
        wr_q    <= DataWr[10];
        rd_q    <= DataWr[11];
        ack_q   <= DataWr[12];
        state_q <= ent_st_d;
        qtr_q   <= 2'd0;
        bit_q   <= 4'd0;
        cnt_q   <= div_q;
        if (ent_st_d != S_IDLE)
          {pull_q, scl_q} <= pads(ent_st_d, 2'd0, bit_pull(DataWr[10], 4'd0, DataWr[7:0], DataWr[12]));
        if (ent_st_d == S_START) held_q <= 1'b1;
      end else if (busy_q) begin
        if (state_q == S_IDLE) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          // Last clock of SCL-high quarter 1 is the sample point.
          if (state_q == S_BIT && qtr_q == 2'd1) begin
            if (bit_q == 4'd8) begin
              if (wr_q) rx_nack_q <= SdaIn;
            end else if (!wr_q) begin
              rx_q <= {rx_q[6:0], SdaIn};
            end
          end
          if (fin_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            if (state_q == S_STOP) held_q <= 1'b0;
          end else begin
            state_q <= st_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            cnt_q   <= div_q;
            {pull_q, scl_q} <= pads(st_d, qtr_d, bit_pull(wr_q, bit_d, tx_q, ack_q));
          end
        end
      end
    end
  end

  // An empty command keeps the legacy pads, so only real phases or a held bus select the engine.
  assign eng_pads = held_q | (busy_q & (state_q != S_IDLE));
  assign SdaOut   = eng_pads ? pull_q : (sda_dir_q & ~sda_out_reg_q);
  assign Scl      = eng_pads ? scl_q : ~scl_reg_q;
  assign Irq      = done_q & irq_en_q;

  always_comb begin
    case (Addr)
      3'd0:    DataRd = {8'd0, irq_en_q, held_q, done_q, rx_nack_q, busy_q, sda_dir_q, scl_reg_q, SdaIn};
      3'd1:    DataRd = 16'(div_q);
      3'd2:    DataRd = {8'd0, rx_q};
      default: DataRd = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_engine.sv
// tb/tb_i2c_master_engine.sv - directed scoreboard bench for i2c_master_engine
module tb_i2c_master_engine;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [2:0]  Addr = 3'd0;
  logic [15:0] DataRd;
  logic [15:0] DataWr = 16'd0;
  logic        En = 1'b0, Rd = 1'b0, Wr = 1'b0;
  logic        SdaOut, SdaIn, Scl, Irq;
  logic        slave_rel = 1'b1;

  int   total = 0, bad = 0;
  int   stop_seen, busy_n;
  logic exp_q[$];
  logic [15:0] d;

  always #5 Clk = ~Clk;

  assign SdaIn = ~SdaOut & slave_rel;

  i2c_master_engine #(.DIV_W(10), .DIV_RESET(124)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataRd(DataRd), .DataWr(DataWr),
    .En(En), .Rd(Rd), .Wr(Wr), .SdaOut(SdaOut), .SdaIn(SdaIn), .Scl(Scl), .Irq(Irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] v);
    @(negedge Clk);
    Addr = a; DataWr = v; En = 1'b1; Wr = 1'b1;
    @(negedge Clk);
    Addr = 3'd0; En = 1'b0; Wr = 1'b0;
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] v);
    @(negedge Clk);
    Addr = a; En = 1'b1; Rd = 1'b1;
    #1;
    v = DataRd;
    Addr = 3'd0; En = 1'b0; Rd = 1'b0;
  endtask

  task automatic push_bits(input logic [9:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  // inj: 0 plain, 1 DIV/CMD writes while busy, 2 reset mid-byte
  task automatic run_cmd(input logic [15:0] cmd, input logic [10:0] pat, input int inj);
    logic scl_prev, sda_prev, busy, got, timed_out;
    int   rises;
    rises = 0; stop_seen = 0; busy_n = 0; timed_out = 1'b1;
    slave_rel = pat[0];
    @(negedge Clk);
    Addr = 3'd2; DataWr = cmd; En = 1'b1; Wr = 1'b1;
    #1;
    scl_prev = Scl; sda_prev = SdaIn;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      if (i == 0) begin Addr = 3'd0; En = 1'b0; Wr = 1'b0; end
      #1;
      busy = (Addr == 3'd0) ? DataRd[3] : 1'b1;
      if (!busy) begin timed_out = 1'b0; break; end
      busy_n++;
      if (inj != 2) begin
        if (!scl_prev && Scl) begin
          check("sb_underflow", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check("sda_at_scl_rise", SdaIn, got);
          end
          rises++;
        end
        if (scl_prev && Scl && !sda_prev && SdaIn) stop_seen++;
        sda_prev = SdaIn;
        if (scl_prev && !Scl && rises <= 10) slave_rel = pat[rises];
      end
      scl_prev = Scl;
      if (inj == 1 && busy_n == 3) begin
        Addr = 3'd1; DataWr = 16'h0007; En = 1'b1; Wr = 1'b1;
      end else if (inj == 1 && busy_n == 4) begin
        Addr = 3'd2; DataWr = 16'h0000;
      end else if (inj == 1 && busy_n == 5) begin
        Addr = 3'd0; En = 1'b0; Wr = 1'b0;
      end
      if (inj == 2 && busy_n == 44) begin
        check("pre_reset_sda_pull", SdaOut, 1);
        Reset = 1'b0;
        #1;
        check("reset_sdaout_now", SdaOut, 0);
        check("reset_scl_now", Scl, 1);
      end
    end
    check("busy_timeout", timed_out, 0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk); #1;
    check("rst_sdaout", SdaOut, 0);
    check("rst_scl", Scl, 1);
    check("rst_irq", Irq, 0);
    bus_read(3'd0, d); check("rst_status", d, 16'h0001);
    bus_read(3'd1, d); check("rst_div", d, 16'd124);
    bus_read(3'd2, d); check("rst_rxdata", d, 16'h0000);

    bus_write(3'd1, 16'd1);
    push_bits(10'b1010_0101_0, 9);
    run_cmd(16'h05A5, 11'h6FF, 0);
    check("wr_busy_clocks", busy_n, 80);
    check("wr_sb_left", exp_q.size(), 0);
    bus_read(3'd0, d); check("wr_status", d, 16'h0061);
    check("wr_scl_held_low", Scl, 0);

    push_bits(10'b0011_1100_10, 10);
    run_cmd(16'h1A00, 11'h73C, 0);
    check("rd_busy_clocks", busy_n, 80);
    check("rd_stop_edge", stop_seen, 1);
    check("rd_sb_left", exp_q.size(), 0);
    bus_read(3'd2, d); check("rd_rxdata", d, 16'h003C);
    bus_read(3'd0, d); check("rd_status", d, 16'h0021);
    check("rd_sdaout_idle", SdaOut, 0);
    check("rd_scl_idle", Scl, 1);

    bus_write(3'd0, 16'h0006);
    check("bb_sdaout", SdaOut, 1);
    check("bb_scl", Scl, 0);
    bus_write(3'd0, 16'h0000);
    check("bb_release_sda", SdaOut, 0);

    push_bits(10'b0000_0000_1, 9);
    run_cmd(16'h0400, 11'h7FF, 1);
    check("busy_wr_clocks", busy_n, 72);
    check("busy_wr_sb_left", exp_q.size(), 0);
    bus_read(3'd1, d); check("div_locked", d, 16'd1);
    bus_read(3'd0, d); check("busy_wr_status", d, 16'h0031);

    bus_write(3'd0, 16'h0080);
    run_cmd(16'h0000, 11'h7FF, 0);
    check("nop_busy_clocks", busy_n, 1);
    check("nop_irq", Irq, 1);
    bus_write(3'd0, 16'h00A0);
    check("irq_cleared", Irq, 0);
    bus_read(3'd0, d); check("irq_status", d, 16'h0091);

    run_cmd(16'h05A5, 11'h7FF, 2);
    exp_q.delete();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk); #1;
    check("post_rst_sdaout", SdaOut, 0);
    check("post_rst_scl", Scl, 1);
    check("post_rst_irq", Irq, 0);
    bus_read(3'd0, d); check("post_rst_status", d, 16'h0001);
    bus_read(3'd1, d); check("post_rst_div", d, 16'd124);
    bus_read(3'd2, d); check("post_rst_rxdata", d, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
